microsequencer: RTL
===================

Name: microsequencer

Overview:
- Next-state address logic and state register for the microprogrammed control unit.
- Consumes the sequencing fields of the current 45-bit microword: next-state select, invert, condition select and CR jump target.
- Produces the 7-bit registered index that addresses the microstore ROM, which decodes it combinationally in the same cycle.
- Adds a memory-wait watchdog and an undefined-instruction trap.

Parameters:
ADDR_W, 7, microstore address width
RESET_ADDR, 7'd0, index after reset (fetch entry)
FAULT_ADDR, 7'd126, trap entry on MOC timeout
UNDEF_ADDR, 7'd127, trap entry on undefined instruction decode
MOC_TIMEOUT, 15, max consecutive wait cycles before trap (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ns  in  3  next-state select field of current microword
inv  in  1  invert selected condition
cond_sel  in  2  condition select: 00 MOC, 01 cond_true, 10 irq, 11 constant 1
cr  in  7  jump target field of current microword
enc_addr  in  7  entry address from instruction encoder
undef  in  1  encoder flags unsupported instruction
moc  in  1  memory operation complete
cond_true  in  1  ARM condition-code tester result
irq  in  1  interrupt pending (level)
stall  in  1  global freeze
index  out  7  registered microstore address
waiting  out  1  combinational: current cycle is a hold on ns=6 with condition false
mem_fault  out  1  one-cycle registered pulse on watchdog trap

Behaviour:
- Reset (reset=0, async): index=RESET_ADDR, watchdog count=0, mem_fault=0. First rising edge after release evaluates the microword at RESET_ADDR.
- Condition: c = (selected source) XOR inv. cond_sel=11 with inv=1 gives c=0.
- Incrementer: incr = index+1 mod 128; 127 wraps to 0.
- Next index per ns, evaluated each rising edge:
  - 000 decode: undef ? UNDEF_ADDR : enc_addr
  - 001 fetch: RESET_ADDR
  - 010 jump: cr
  - 011 increment: incr
  - 100 conditional branch: c ? cr : incr
  - 101 conditional decode: c ? (undef ? UNDEF_ADDR : enc_addr) : incr
  - 110 wait: c ? incr : index (hold)
  - 111 interrupt test: irq ? cr : incr. cond_sel and inv are ignored.
- Watchdog:
  - Count increments (saturating at 255) each edge on which waiting=1.
  - Count clears on any edge where waiting=0.
  - Trap: on an edge where waiting=1 and count==MOC_TIMEOUT-1, next index=FAULT_ADDR, count clears, mem_fault=1 for exactly the following cycle.
  - MOC arriving on the trap edge wins: c=1, so no trap.
- Stall: stall=1 freezes index and watchdog count and forces mem_fault=0 next cycle. Stall has priority over all ns actions; only reset overrides it. waiting is still driven combinationally during stall.
- Latency:
  - Index changes one edge after the microword fields are presented.
  - Each microword is active for at least one full cycle.
- Reset mid-wait: index returns to RESET_ADDR and count clears immediately, regardless of clk.
- Inputs are sampled only at rising edges. Combinational glitches between edges have no effect.
- Outputs are never X after reset. Unknown ns values do not exist: all 8 codes are defined.

Test Plan:
- Reset check: reset=0 mid-cycle with index=7'd45 -> index=0 immediately, mem_fault=0. Release; ns=011 -> index 1, 2, 3 on successive edges.
- Decode path: index=2, ns=000, enc_addr=7'd40, undef=0 -> index=40. Repeat with undef=1 -> index=127.
- Conditional branch: ns=100, cond_sel=01, cr=7'd23, index=10. cond_true=1, inv=0 -> index=23. cond_true=1, inv=1 -> index=11. Wrap: ns=011 at index=127 -> 0.
- Memory wait: ns=110, cond_sel=00, index=5. moc=0 for 3 edges -> index holds 5, waiting=1. moc=1 on 4th edge -> index=6, waiting=0.
- Watchdog: ns=110, moc held 0, MOC_TIMEOUT=15 -> index holds 5 for 14 edges. 15th edge -> index=126; mem_fault=1 for exactly one cycle, then 0. Same run with moc=1 on the 15th edge -> index=6, no fault.
- Stall: stall=1 for 4 cycles during a wait at count=10 -> index and count frozen. After release, trap occurs on the 5th further waiting edge. Stall with ns=010, cr=7'd80 -> index unchanged until stall=0, then index=80.

Source files
------------

// File: rtl/microsequencer.sv
// Next-address logic and microstore index register for the microprogrammed
// control unit, with a memory-wait watchdog and an undefined-instruction trap.
module microsequencer #(
  parameter int unsigned         ADDR_W      = 7,
  parameter logic [ADDR_W-1:0]   RESET_ADDR  = 7'd0,
  parameter logic [ADDR_W-1:0]   FAULT_ADDR  = 7'd126,
  parameter logic [ADDR_W-1:0]   UNDEF_ADDR  = 7'd127,
  parameter int unsigned         MOC_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ns,
  input  logic              inv,
  input  logic [1:0]        cond_sel,
  input  logic [ADDR_W-1:0] cr,
  input  logic [ADDR_W-1:0] enc_addr,
  input  logic              undef,
  input  logic              moc,
  input  logic              cond_true,
  input  logic              irq,
  input  logic              stall,
  output logic [ADDR_W-1:0] index,
  output logic              waiting,
  output logic              mem_fault
);

  typedef enum logic [2:0] {
    NS_DECODE  = 3'b000,
    NS_FETCH   = 3'b001,
    NS_JUMP    = 3'b010,
    NS_INCR    = 3'b011,
    NS_CBRANCH = 3'b100,
    NS_CDECODE = 3'b101,
    NS_WAIT    = 3'b110,
    NS_IRQ     = 3'b111
  } ns_e;

  localparam logic [7:0] TRIP_COUNT = 8'(MOC_TIMEOUT - 1);

  ns_e               op;
  logic              src;
  logic              c;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] decode_addr;
  logic [ADDR_W-1:0] next_index;
  logic [7:0]        count;
  logic [7:0]        next_count;
  logic              trap;

  assign op          = ns_e'(ns);
  assign incr        = index + 1'b1;
  assign decode_addr = undef ? UNDEF_ADDR : enc_addr;

  always_comb begin
    src = 1'b1;
    unique case (cond_sel)
      2'b00:   src = moc;
      2'b01:   src = cond_true;
      2'b10:   src = irq;
      default: src = 1'b1;
    endcase
  end

  assign c       = src ^ inv;
  assign waiting = (op == NS_WAIT) && !c;
  assign trap    = waiting && (count == TRIP_COUNT);

  always_comb begin
    next_index = index;
    unique case (op)
      NS_DECODE:  next_index = decode_addr;
      NS_FETCH:   next_index = RESET_ADDR;
      NS_JUMP:    next_index = cr;
      NS_INCR:    next_index = incr;
      NS_CBRANCH: next_index = c ? cr : incr;
      NS_CDECODE: next_index = c ? decode_addr : incr;
      NS_WAIT:    next_index = c ? incr : index;
      NS_IRQ:     next_index = irq ? cr : incr;
      default:    next_index = index;
    endcase
    // Watchdog expiry overrides the hold of a wait that never completed.
    if (trap) begin
      next_index = FAULT_ADDR;
    end
  end

  always_comb begin
    next_count = '0;
    if (waiting && !trap) begin
      next_count = (count == 8'hFF) ? count : count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index     <= RESET_ADDR;
      count     <= '0;
      mem_fault <= 1'b0;
    end else if (stall) begin
      mem_fault <= 1'b0;
    end else begin
      index     <= next_index;
      count     <= next_count;
      mem_fault <= trap;
    end
  end

endmodule
